// File: rtl/fp_mac_pkg.sv
// Floating-point format constants, field types and pack/unpack helpers shared
// by the multi-channel MAC datapath. The FP format is fixed here.
package fp_mac_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = 2 ** (EXP_W - 1) - 1;
  localparam int XE_W  = EXP_W + 3;

  localparam logic [EXP_W-1:0] MAX_EXP = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [MAN_W-1:0] MAX_MAN = '1;
  localparam logic signed [XE_W-1:0] XE_ONE = XE_W'(1);
  localparam logic signed [XE_W-1:0] XE_SAT = XE_W'(2 ** EXP_W - 1);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  typedef struct packed {
    logic             zero;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
  } fp_unp_t;

  // Subnormals become +0; Inf/NaN encodings become max finite of the same sign.
  function automatic fp_t flush_sub(fp_t x);
    fp_t r;
    r = x;
    if (x.exp == '0) begin
      r = '0;
    end else if (x.exp == '1) begin
      r.exp = MAX_EXP;
      r.man = MAX_MAN;
    end
    return r;
  endfunction

  function automatic fp_unp_t unpack(fp_t x);
    fp_t     f;
    fp_unp_t u;
    f      = flush_sub(x);
    u.zero = (f.exp == '0);
    u.sign = f.sign;
    u.exp  = f.exp;
    u.sig  = {~u.zero, f.man};
    return u;
  endfunction

  function automatic fp_t pack_sat(logic sign, logic signed [XE_W-1:0] exp,
                                   logic [MAN_W-1:0] man);
    fp_t r;
    if (exp < XE_ONE) begin
      r = '0;
    end else if (exp >= XE_SAT) begin
      r = {sign, MAX_EXP, MAX_MAN};
    end else begin
      r = {sign, exp[EXP_W-1:0], man};
    end
    return r;
  endfunction
endpackage

// File: rtl/fp_add_norm.sv
// Combinational FP adder: align the smaller operand, add or subtract, then
// renormalise with a leading-zero shift. Truncates toward zero.
module fp_add_norm
  import fp_mac_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  // Significand plus two guard bits below the LSB.
  localparam int XW = MAN_W + 3;
  localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(MAN_W + 2);

  fp_unp_t ua, ub, big, sml;
  logic [EXP_W-1:0] d;
  logic [XW-1:0] big_x, sml_x, diff, norm;
  logic [XW:0] add_x;
  logic [XE_W-1:0] lz;
  logic found, zero;
  logic signed [XE_W-1:0] r_exp;
  logic [MAN_W-1:0] r_man;

  always_comb begin
    ua    = unpack(fp_t'(a));
    ub    = unpack(fp_t'(b));
    big   = ua;
    sml   = ub;
    if ({ub.exp, ub.sig} > {ua.exp, ua.sig}) begin
      big = ub;
      sml = ua;
    end
    d     = big.exp - sml.exp;
    big_x = {big.sig, 2'b00};
    sml_x = (d >= SH_MAX) ? '0 : ({sml.sig, 2'b00} >> d);
    add_x = '0;
    diff  = '0;
    norm  = '0;
    lz    = '0;
    found = 1'b0;
    r_exp = $signed({3'b000, big.exp});
    r_man = '0;
    if (big.sign == sml.sign) begin
      add_x = {1'b0, big_x} + {1'b0, sml_x};
      zero  = (add_x == '0);
      if (add_x[XW]) begin
        r_exp = r_exp + XE_ONE;
        r_man = add_x[XW-1:3];
      end else begin
        r_man = add_x[XW-2:2];
      end
    end else begin
      diff = big_x - sml_x;
      zero = (diff == '0);
      for (int i = 0; i < XW; i++) begin
        if (!found && diff[XW-1-i]) begin
          lz    = XE_W'(i);
          found = 1'b1;
        end
      end
      norm  = diff << lz;
      r_man = norm[XW-2:2];
      r_exp = r_exp - $signed(lz);
    end
    sum = zero ? '0 : pack_sat(big.sign, r_exp, r_man);
  end
endmodule

// File: rtl/fp_mac_multich.sv
// Three-stage FP multiply-accumulate with NUM_CH tagged accumulators; a pair
// flagged last emits its channel's sum and clears that accumulator.
module fp_mac_multich
  import fp_mac_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [CH_W-1:0] in_ch,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [CH_W-1:0] out_ch
);
  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; out_valid/out_data/out_ch hold until out_ready is seen.
  localparam int NSLOT = 2 ** CH_W;

  function automatic logic [NSLOT-1:0] ch_ok_mask();
    logic [NSLOT-1:0] m;
    for (int i = 0; i < NSLOT; i++) m[i] = (i < NUM_CH);
    return m;
  endfunction
  localparam logic [NSLOT-1:0] CH_OK = ch_ok_mask();
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W + 2)'(BIAS);

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // S1 combinational: unpack, exponent sum, full significand product.
  fp_unp_t ua, ub;
  logic signed [EXP_W+1:0] exp_sum_c;
  logic [2*MAN_W+1:0] prod_c;
  assign ua        = unpack(fp_t'(in_a));
  assign ub        = unpack(fp_t'(in_b));
  assign exp_sum_c = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - BIAS_S;
  assign prod_c    = {{(MAN_W+1){1'b0}}, ua.sig} * {{(MAN_W+1){1'b0}}, ub.sig};

  logic                    s1_valid, s1_zero, s1_sign, s1_last;
  logic signed [EXP_W+1:0] s1_exp;
  logic [2*MAN_W+1:0]      s1_prod;
  logic [CH_W-1:0]         s1_ch;

  // S2 combinational: product lies in [1,4); normalise and truncate.
  logic signed [XE_W-1:0] n_exp;
  logic [MAN_W-1:0]       n_man;
  logic [W-1:0]           s2_word_c;
  always_comb begin
    n_exp = $signed({s1_exp[EXP_W+1], s1_exp});
    n_man = s1_prod[2*MAN_W-1:MAN_W];
    if (s1_prod[2*MAN_W+1]) begin
      n_exp = n_exp + XE_ONE;
      n_man = s1_prod[2*MAN_W:MAN_W+1];
    end
    s2_word_c = s1_zero ? '0 : pack_sat(s1_sign, n_exp, n_man);
  end

  logic            s2_valid, s2_last;
  logic [W-1:0]    s2_word;
  logic [CH_W-1:0] s2_ch;

  logic [W-1:0] acc [NSLOT];
  logic [W-1:0] sum_c;

  fp_add_norm u_add (
    .a   (acc[s2_ch]),
    .b   (s2_word),
    .sum (sum_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sign   <= 1'b0;
      s1_last   <= 1'b0;
      s1_exp    <= '0;
      s1_prod   <= '0;
      s1_ch     <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_word   <= '0;
      s2_ch     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      for (int i = 0; i < NSLOT; i++) acc[i] <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_zero   <= ua.zero | ub.zero;
      s1_sign   <= ua.sign ^ ub.sign;
      s1_last   <= in_last;
      s1_exp    <= exp_sum_c;
      s1_prod   <= prod_c;
      s1_ch     <= in_ch;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_word   <= s2_word_c;
      s2_ch     <= s1_ch;
      out_valid <= 1'b0;
      // Out-of-range channels fall through: no accumulator write, no result.
      if (s2_valid && CH_OK[s2_ch]) begin
        acc[s2_ch] <= s2_last ? '0 : sum_c;
        if (s2_last) begin
          out_valid <= 1'b1;
          out_data  <= sum_c;
          out_ch    <= s2_ch;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_mac_multich.sv
// Directed bench for fp_mac_multich: vector table through the pipeline plus
// hand sequences for backpressure and mid-run reset.
module tb_fp_mac_multich;
  import fp_mac_pkg::*;

  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a, in_b;
  logic [CH_W-1:0] in_ch;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [CH_W-1:0] out_ch;

  fp_mac_multich #(.NUM_CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ch     (in_ch),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [CH_W-1:0] ch;
    logic            last;
    logic [W-1:0]    exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  logic [W-1:0]    exp_q[$];
  logic [CH_W-1:0] ch_q[$];
  int              acc_q[$];
  bit              lat_q[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [CH_W-1:0] ch, input logic last,
                      input logic [W-1:0] exp, input bit lat);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_ch    = ch;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else if (last) begin
      exp_q.push_back(exp);
      ch_q.push_back(ch);
      acc_q.push_back(cyc);
      lat_q.push_back(lat);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every output handshake is matched against the expected queue.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        automatic logic [W-1:0]    e  = exp_q.pop_front();
        automatic logic [CH_W-1:0] c  = ch_q.pop_front();
        automatic int              t0 = acc_q.pop_front();
        automatic bit              l  = lat_q.pop_front();
        check("out_data", 32'(out_data), 32'(e));
        check("out_ch", 32'(out_ch), 32'(c));
        if (l) check("latency", 32'(cyc - t0), 32'd3);
      end
    end
  end

  initial begin
    vt[0]  = '{16'h3C00, 16'h4000, 2'd0, 1'b0, 16'h0000};
    vt[1]  = '{16'h4000, 16'h3800, 2'd0, 1'b1, 16'h4200};
    vt[2]  = '{16'h4000, 16'h4000, 2'd1, 1'b0, 16'h0000};
    vt[3]  = '{16'h3C00, 16'h4200, 2'd2, 1'b1, 16'h4200};
    vt[4]  = '{16'h4000, 16'h4000, 2'd1, 1'b1, 16'h4800};
    vt[5]  = '{16'h7BFF, 16'h7BFF, 2'd0, 1'b1, 16'h7BFF};
    vt[6]  = '{16'h3C00, 16'h3C00, 2'd3, 1'b0, 16'h0000};
    vt[7]  = '{16'hBC00, 16'h3C00, 2'd3, 1'b1, 16'h0000};
    vt[8]  = '{16'h0001, 16'h7BFF, 2'd1, 1'b1, 16'h0000};
    vt[9]  = '{16'h0000, 16'h4000, 2'd2, 1'b0, 16'h0000};
    vt[10] = '{16'h3C00, 16'h3C00, 2'd2, 1'b1, 16'h3C00};
    vt[11] = '{16'hBC00, 16'h4000, 2'd1, 1'b1, 16'hC000};
    vt[12] = '{16'h4200, 16'h3C00, 2'd3, 1'b0, 16'h0000};
    vt[13] = '{16'hBC00, 16'h4000, 2'd3, 1'b1, 16'h3C00};
    vt[14] = '{16'h3C00, 16'h3C00, 2'd0, 1'b1, 16'h3C00};
    vt[15] = '{16'h7C00, 16'h3C00, 2'd2, 1'b0, 16'h0000};
    vt[16] = '{16'h7BFF, 16'h3C00, 2'd2, 1'b1, 16'h7BFF};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_ch     = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++)
      send(vt[i].a, vt[i].b, vt[i].ch, vt[i].last, vt[i].exp, 1'b1);
    idle(1);
    wait_drain();

    // Backpressure: two results queued behind a stalled consumer.
    @(negedge clk);
    out_ready = 1'b0;
    send(16'h4000, 16'h4000, 2'd0, 1'b1, 16'h4400, 1'b0);
    send(16'h3C00, 16'h4000, 2'd1, 1'b1, 16'h4000, 1'b0);
    idle(1);
    begin
      int w;
      w = 0;
      while (!out_valid && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    #1;
    check("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_data", 32'(out_data), 32'h4400);
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();

    // Reset with partial sums in flight on ch3.
    send(16'h4000, 16'h4000, 2'd3, 1'b0, 16'h0000, 1'b1);
    send(16'h4000, 16'h4000, 2'd3, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1;
    end
    send(16'h3C00, 16'h3800, 2'd3, 1'b1, 16'h3800, 1'b1);
    idle(1);
    wait_drain();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
